piso_shift_register: RTL and testbench

//  Parallel-in/serial-out shift register: the transmit-side counterpart of the

---
 rtl/piso_shift_register.sv | 117 +++++++++++
 tb/tb_piso_shift_register.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/piso_shift_register.sv
// Parallel-in/serial-out shift register with valid/ready load and valid/last serial qualifiers.
// Optional even-parity trailer bit when PISO_PARITY_EN is defined.
module piso_shift_register #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_valid_i,
   output logic             load_ready_o,
   input  logic [WIDTH-1:0] data_i,
   input  logic             ser_en_i,
   output logic             ser_o,
   output logic             ser_valid_o,
   output logic             ser_last_o,
   output logic             busy_o
);

`ifdef PISO_PARITY_EN
   localparam int FRAME_LEN = WIDTH + 1;
`else
   localparam int FRAME_LEN = WIDTH;
`endif
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);

   typedef enum logic {S_IDLE, S_SHIFT} state_t;

   state_t           r_state, w_state_next;
   logic [WIDTH-1:0] r_shift, w_shift_next;
   logic [CW-1:0]    r_cnt, w_cnt_next;
   logic             r_ready, w_ready_next;
   logic             w_last;
   logic             w_data_bit;
`ifdef PISO_PARITY_EN
   logic             r_par, w_par_next;
`endif

   assign w_last     = (r_state == S_SHIFT) && (r_cnt == LAST_CNT);
   assign w_data_bit = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_shift <= '0;
         r_cnt   <= '0;
         r_ready <= 1'b0;
`ifdef PISO_PARITY_EN
         r_par   <= 1'b0;
`endif
      end else begin
         r_state <= w_state_next;
         r_shift <= w_shift_next;
         r_cnt   <= w_cnt_next;
         r_ready <= w_ready_next;
`ifdef PISO_PARITY_EN
         r_par   <= w_par_next;
`endif
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_shift_next = r_shift;
      w_cnt_next   = r_cnt;
      w_ready_next = r_ready;
`ifdef PISO_PARITY_EN
      w_par_next   = r_par;
`endif
      case (r_state)
         S_IDLE: begin
            if (load_valid_i && r_ready) begin
               w_state_next = S_SHIFT;
               w_shift_next = data_i;
               w_cnt_next   = '0;
               w_ready_next = 1'b0;
`ifdef PISO_PARITY_EN
               w_par_next   = ^data_i;
`endif
            end else begin
               w_ready_next = 1'b1;
            end
         end
         S_SHIFT: begin
            if (ser_en_i) begin
               // Zero fill: the register is empty once every data bit has left.
               if (MSB_FIRST) begin
                  w_shift_next = {r_shift[WIDTH-2:0], 1'b0};
               end else begin
                  w_shift_next = {1'b0, r_shift[WIDTH-1:1]};
               end
               if (w_last) begin
                  w_state_next = S_IDLE;
                  w_cnt_next   = '0;
                  w_ready_next = 1'b1;
               end else begin
                  w_cnt_next   = r_cnt + 1'b1;
               end
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   assign load_ready_o = r_ready;
   assign ser_valid_o  = (r_state == S_SHIFT);
   assign busy_o       = (r_state == S_SHIFT);
   assign ser_last_o   = w_last;
`ifdef PISO_PARITY_EN
   assign ser_o        = (r_cnt == CW'(WIDTH)) ? r_par : w_data_bit;
`else
   assign ser_o        = w_data_bit;
`endif

endmodule

// File: tb/tb_piso_shift_register.sv
// Bench for piso_shift_register: MSB-first and LSB-first instances share stimulus and are
// checked every cycle against a queue-based frame model plus literal frame expectations.
module tb_piso_shift_register;

`ifdef PISO_PARITY_EN
   localparam int FL = 9;
   localparam logic [15:0] E_A5_M = 16'h014A, E_3C_M = 16'h0078, E_3C_L = 16'h003C;
   localparam logic [15:0] E_F0_M = 16'h01E0, E_11_M = 16'h0022;
   localparam logic [15:0] E_07_M = 16'h000F, E_07_L = 16'h0107;
`else
   localparam int FL = 8;
   localparam logic [15:0] E_A5_M = 16'h00A5, E_3C_M = 16'h003C, E_3C_L = 16'h003C;
   localparam logic [15:0] E_F0_M = 16'h00F0, E_11_M = 16'h0011;
   localparam logic [15:0] E_07_M = 16'h0007, E_07_L = 16'h0007;
`endif

   logic       clk = 1'b0;
   logic       rst_n, load_valid, ser_en;
   logic [7:0] data;
   logic       m_ready, m_ser, m_valid, m_last, m_busy;
   logic       l_ready, l_ser, l_valid, l_last, l_busy;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   // Model: one queue of pending frame bits per bit order, plus the ready flag.
   bit qm[$];
   bit ql[$];
   bit mdl_ready = 1'b0;

   always #5 clk = ~clk;

   piso_shift_register #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
      .clk(clk), .rst_n(rst_n), .load_valid_i(load_valid), .load_ready_o(m_ready),
      .data_i(data), .ser_en_i(ser_en), .ser_o(m_ser), .ser_valid_o(m_valid),
      .ser_last_o(m_last), .busy_o(m_busy));

   piso_shift_register #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
      .clk(clk), .rst_n(rst_n), .load_valid_i(load_valid), .load_ready_o(l_ready),
      .data_i(data), .ser_en_i(ser_en), .ser_o(l_ser), .ser_valid_o(l_valid),
      .ser_last_o(l_last), .busy_o(l_busy));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      if (!rst_n) begin
         qm.delete();
         ql.delete();
         mdl_ready = 1'b0;
      end else begin
         if (qm.size() != 0) begin
            if (ser_en) begin
               void'(qm.pop_front());
               void'(ql.pop_front());
            end
         end else if (load_valid && mdl_ready) begin
            for (int i = 0; i < 8; i++) begin
               qm.push_back(data[7-i]);
               ql.push_back(data[i]);
            end
`ifdef PISO_PARITY_EN
            qm.push_back(^data);
            ql.push_back(^data);
`endif
         end
         mdl_ready = (qm.size() == 0);
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("ready_m", m_ready, mdl_ready);
         chk("ready_l", l_ready, mdl_ready);
         chk("valid_m", m_valid, qm.size() != 0);
         chk("valid_l", l_valid, ql.size() != 0);
         chk("busy_m", m_busy, qm.size() != 0);
         chk("busy_l", l_busy, ql.size() != 0);
         chk("last_m", m_last, qm.size() == 1);
         chk("last_l", l_last, ql.size() == 1);
         if (qm.size() != 0) begin
            chk("ser_m", m_ser, qm[0]);
            chk("ser_l", l_ser, ql[0]);
         end
      end
   end

   task automatic load_word(input logic [7:0] w);
      int k;
      k = 0;
      while (!m_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("load_wait_timeout", m_ready, 1'b1);
      load_valid = 1'b1;
      data       = w;
      @(negedge clk);
      load_valid = 1'b0;
      data       = 8'hC3;
   endtask

   // en_mode 0: enable every cycle; 1: enable one cycle in three.
   task automatic run_frame(input int en_mode, input string nm,
                            input logic [15:0] exp_m, input logic [15:0] exp_l, input bit chk_l);
      logic [15:0] bm, bl;
      int nbits, lastn;
      bit done;
      bm = '0; bl = '0; nbits = 0; lastn = -1; done = 1'b0;
      for (int k = 0; k < 60 && !done; k++) begin
         ser_en = (en_mode == 0) ? 1'b1 : (k % 3 == 0);
         if (m_valid && ser_en) begin
            bm = {bm[14:0], m_ser};
            bl[nbits] = l_ser;
            nbits++;
            if (m_last) begin
               lastn = nbits;
               done  = 1'b1;
            end
         end
         @(negedge clk);
      end
      ser_en = 1'b1;
      chk({nm, "_done"}, done, 1'b1);
      chk({nm, "_bits_m"}, bm, exp_m);
      if (chk_l) chk({nm, "_bits_l"}, bl, exp_l);
      chk({nm, "_nbits"}, nbits, FL);
      chk({nm, "_lastpos"}, lastn, FL);
      $display("frame %s: msb=%h lsb=%h bits=%0d", nm, bm, bl, nbits);
   endtask

   initial begin
      rst_n = 1'b0; load_valid = 1'b1; data = 8'h5A; ser_en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("rst_ready", {m_ready, l_ready}, 2'b00);
      chk("rst_valid", {m_valid, l_valid}, 2'b00);
      chk("rst_last", {m_last, l_last}, 2'b00);
      chk("rst_busy", {m_busy, l_busy}, 2'b00);
      chk("rst_ser", {m_ser, l_ser}, 2'b00);
      $display("reset: outputs ready=%b valid=%b", m_ready, m_valid);
      rst_n = 1'b1; load_valid = 1'b0; cmp_en = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", m_ready, 1'b1);

      load_word(8'hA5);
      run_frame(0, "A5_msb", E_A5_M, 16'h0, 1'b0);
      chk("idle_ready", m_ready, 1'b1);
      chk("idle_valid", m_valid, 1'b0);

      load_word(8'h3C);
      run_frame(0, "3C_lsb", E_3C_M, E_3C_L, 1'b1);

      load_word(8'hF0);
      run_frame(1, "F0_gaps", E_F0_M, 16'h0, 1'b0);

      // Offer 0x11 during the 0xA5 frame; it may only be taken once ready returns.
      load_word(8'hA5);
      load_valid = 1'b1; data = 8'h11;
      run_frame(0, "A5_busy", E_A5_M, 16'h0, 1'b0);
      @(negedge clk);
      load_valid = 1'b0; data = 8'hFF;
      run_frame(0, "11_after", E_11_M, 16'h0, 1'b0);

      load_word(8'h07);
      run_frame(0, "07_par", E_07_M, E_07_L, 1'b1);

      load_word(8'hA5);
      ser_en = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_valid", m_valid, 1'b0);
      chk("midrst_last", m_last, 1'b0);
      chk("midrst_busy", m_busy, 1'b0);
      $display("reset mid-frame: valid=%b last=%b", m_valid, m_last);
      rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_ready", m_ready, 1'b1);

      load_word(8'h3C);
      run_frame(0, "3C_recover", E_3C_M, E_3C_L, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
